// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: access size encodings and word width
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned_access = 1'b0;
      SZ_HALF: misaligned_access = lo[0];
      default: misaligned_access = |lo;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - extracts a byte/half/word lane from a memory word and extends it
module load_formatter
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [WORD_W-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{lo, 3'b000} +: 8];
  assign h = lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{sign_ext & b[7]}}, b};
      SZ_HALF: data = {{16{sign_ext & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM-stage byte-addressable data memory, registered load path (option: DATA_MEM_MISALIGN_TRAP_EN)
module data_mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic              stall,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  output logic              misaligned
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lo;
  logic              go;
  logic              req;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic [3:0]        be;
  logic [WORD_W-1:0] wlane;
  logic [WORD_W-1:0] fmt;
  logic              unused_addr_bits;

  assign idx = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis = misaligned_access(size, addr[1:0]);
  assign lo  = addr[1:0];
  assign go  = ~mis;
`else
  // Misaligned halves/words silently round down to their natural boundary.
  always_comb begin
    lo = 2'b00;
    case (size)
      SZ_BYTE: lo = addr[1:0];
      SZ_HALF: lo = {addr[1], 1'b0};
      default: lo = 2'b00;
    endcase
  end
  assign go = 1'b1;
`endif

  assign req      = (mem_read | mem_write) & ~stall & ~rst;
  assign accept   = req & go;
  assign do_write = accept & mem_write;
  assign do_read  = accept & mem_read & ~mem_write;

  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lo;
        wlane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
  end

  load_formatter u_fmt (
    .word     (mem[idx]),
    .lo       (lo),
    .size     (size),
    .sign_ext (sign_ext),
    .data     (fmt)
  );

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      rvalid <= do_read;
      if (do_read) rdata <= fmt;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      misaligned <= req & mis;
`else
      misaligned <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed bench for data_mem_stage with byte-array reference model
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        sign_ext = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;

  data_mem_stage #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .stall      (stall),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [7:0]  mm [1024];
  logic [31:0] exp_rdata  = '0;
  logic        exp_rvalid = 1'b0;
  logic        exp_mis    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Memory as 1024 bytes; every access resolves to a byte run of length 1, 2 or 4.
  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sx, input bit st, input bit rs);
    int n;
    int ba;
    logic [31:0] v;
    exp_rvalid = 1'b0;
    exp_mis    = 1'b0;
    if (rs) begin
      exp_rdata = '0;
      return;
    end
    if (!(rd || wr) || st) return;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ba = int'(a & 32'h3FF);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if ((ba % n) != 0) begin
      exp_mis = 1'b1;
      return;
    end
`else
    ba = ba - (ba % n);
`endif
    if (wr) begin
      for (int k = 0; k < n; k++) mm[ba + k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v = v | ({24'b0, mm[ba + k]} << (8 * k));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      exp_rdata  = v;
      exp_rvalid = 1'b1;
    end
  endtask

  task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input bit sx, input bit st, input bit rs);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    size      = sz;
    sign_ext  = sx;
    stall     = st;
    rst       = rs;
    @(posedge clk);
    model(rd, wr, a, wd, sz, sx, st, rs);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rdata", rdata, exp_rdata);
      chk("model_rvalid", {31'b0, rvalid}, {31'b0, exp_rvalid});
      chk("model_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
    end
  end

  initial begin
    @(negedge clk);
    step(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, 1);
    step(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, 1);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset_misaligned", {31'b0, misaligned}, 32'h0);
    chk_en = 1'b1;

    // rd, wr, addr, wdata, size, sign_ext, stall, rst
    step(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, 0);
    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 0);
    chk("sw_lw", rdata, 32'hDEADBEEF);
    chk("sw_lw_rvalid", {31'b0, rvalid}, 32'h1);
    step(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, 0);
    chk("idle_rvalid", {31'b0, rvalid}, 32'h0);
    chk("idle_hold", rdata, 32'hDEADBEEF);

    step(0, 1, 32'h13, 32'h00000080, 2'd0, 0, 0, 0);
    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 0);
    chk("sb_lw", rdata, 32'h80ADBEEF);
    step(1, 0, 32'h13, 32'h0, 2'd0, 1, 0, 0);
    chk("lb", rdata, 32'hFFFFFF80);
    step(1, 0, 32'h13, 32'h0, 2'd0, 0, 0, 0);
    chk("lbu", rdata, 32'h00000080);
    step(1, 0, 32'h12, 32'h0, 2'd1, 1, 0, 0);
    chk("lh", rdata, 32'hFFFF80AD);
    step(1, 0, 32'h10, 32'h0, 2'd1, 0, 0, 0);
    chk("lhu", rdata, 32'h0000BEEF);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h10, 32'h0, 2'd2, 0, 1, 0);
      chk("stall_rvalid", {31'b0, rvalid}, 32'h0);
      chk("stall_hold", rdata, 32'h0000BEEF);
    end
    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 0);
    chk("stall_release", rdata, 32'h80ADBEEF);

    step(0, 1, 32'h12, 32'h11111111, 2'd2, 0, 0, 0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, misaligned}, 32'h1);
    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 0);
    chk("mis_no_write", rdata, 32'h80ADBEEF);
`else
    chk("mis_tied", {31'b0, misaligned}, 32'h0);
    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 0);
    chk("mis_forced", rdata, 32'h11111111);
`endif
    step(1, 0, 32'h11, 32'h0, 2'd1, 1, 0, 0);

    step(1, 1, 32'h20, 32'h12345678, 2'd2, 0, 0, 0);
    chk("rw_both_rvalid", {31'b0, rvalid}, 32'h0);
    step(1, 0, 32'h20, 32'h0, 2'd3, 0, 0, 0);
    chk("reserved_size", rdata, 32'h12345678);
    step(0, 1, 32'h22, 32'h0000A5B6, 2'd1, 0, 0, 0);
    step(1, 0, 32'h20, 32'h0, 2'd2, 0, 0, 0);
    chk("sh_lw", rdata, 32'hA5B65678);

    step(0, 1, 32'h400, 32'hCAFEF00D, 2'd2, 0, 0, 0);
    step(1, 0, 32'h0, 32'h0, 2'd2, 0, 0, 0);
    chk("wrap", rdata, 32'hCAFEF00D);

    step(1, 0, 32'h10, 32'h0, 2'd2, 0, 0, 1);
    chk("rst_lw_rdata", rdata, 32'h0);
    chk("rst_lw_rvalid", {31'b0, rvalid}, 32'h0);
    step(0, 0, 32'h0, 32'h0, 2'd2, 0, 0, 0);
    chk("rst_after_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_after_rdata", rdata, 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
